// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU issue queue and scheduler.
// Other queues and the ALU reuse precedes() for redirect ordering.
package alu_sched_pkg;

    localparam int iwd  = 4;
    localparam int qsz  = 16;
    localparam int opsz = 64;
    localparam int prn  = 128;
    localparam int tgw  = $clog2(prn);
    localparam int wwd  = 4;
    localparam int pwd  = 256;
    localparam int opw  = $clog2(opsz);
    localparam int cntw = $clog2(qsz) + 1;
    localparam int lnw  = $clog2(iwd);

    // Redirect bundle: opid[15] is the valid bit, topid is the oldest in-flight op.
    typedef struct packed {
        logic [15:0] opid;
        logic [15:0] topid;
    } red_bundle_t;

    // One resident queue entry.
    typedef struct packed {
        logic                 valid;
        logic [15:0]          opid;
        logic [1:0][tgw-1:0]  prs;
        logic [1:0]           rdy;
        logic [pwd-1:0]       payload;
    } sched_entry_t;

    // True when the redirecting op precedes opid, i.e. opid is younger and must go.
    // Ordering is measured as wrapped distance from topid so ring wrap is harmless.
    function automatic logic precedes(input logic [15:0] opid, input red_bundle_t redir);
        logic [opw-1:0] dist_op;
        logic [opw-1:0] dist_redir;
        logic [opw:0]   limit;
        dist_op    = opid[opw-1:0] - redir.topid[opw-1:0];
        dist_redir = redir.opid[opw-1:0] - redir.topid[opw-1:0];
        limit      = {1'b0, dist_redir} + {{opw{1'b0}}, 1'b1};
        return ({1'b0, dist_op} >= limit);
    endfunction

endpackage

// File: rtl/alu_sched_age_select.sv
// Age matrix over the queue slots plus an oldest-first multi-pick network.
// older[i][j] = 1 means slot j holds an op older than slot i.
module alu_sched_age_select
    import alu_sched_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [qsz-1:0]             alloc,
    input  logic [qsz-1:0][qsz-1:0]    alloc_row,
    input  logic [qsz-1:0]             eligible,
    output logic [iwd-1:0][qsz-1:0]    grant
);

    logic [qsz-1:0][qsz-1:0] older;

    // Newly allocated slots take their row; their column is cleared elsewhere since they are youngest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            older <= '0;
        end else begin
            for (int i = 0; i < qsz; i++) begin
                if (alloc[i]) begin
                    older[i] <= alloc_row[i];
                end else begin
                    older[i] <= older[i] & ~alloc;
                end
            end
        end
    end

    // Each round grants the one eligible slot with no older eligible slot left, then removes it.
    always_comb begin
        logic [qsz-1:0] remaining;
        remaining = eligible;
        grant     = '0;
        for (int r = 0; r < iwd; r++) begin
            for (int i = 0; i < qsz; i++) begin
                grant[r][i] = remaining[i] & ~(|(older[i] & remaining));
            end
            remaining = remaining & ~grant[r];
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Out-of-order issue queue for the integer ALU cluster: dispatch, wakeup,
// oldest-first select into a registered issue bundle, and redirect flush.
module alu_sched
    import alu_sched_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  red_bundle_t                   redir,
    output logic                          dis_ready,
    input  logic [iwd-1:0]                dis_valid,
    input  logic [iwd-1:0][15:0]          dis_opid,
    input  logic [iwd-1:0][1:0][tgw-1:0]  dis_prs,
    input  logic [iwd-1:0][1:0]           dis_rdy,
    input  logic [iwd-1:0][pwd-1:0]       dis_payload,
    input  logic [wwd-1:0]                wk_valid,
    input  logic [wwd-1:0][tgw-1:0]       wk_tag,
    input  logic                          alu_ready,
    output logic [iwd-1:0]                iss_valid,
    output logic [iwd-1:0][15:0]          iss_opid,
    output logic [iwd-1:0][1:0][tgw-1:0]  iss_prs,
    output logic [iwd-1:0][pwd-1:0]       iss_payload,
    output logic [cntw-1:0]               count
);

    localparam logic [cntw-1:0] dis_lim = cntw'(qsz - iwd);

    sched_entry_t               entries [qsz];
    sched_entry_t               lane_new [iwd];
    logic [lnw-1:0]             alloc_lane [qsz];
    logic [1:0]                 wake_res [qsz];
    logic [qsz-1:0]             valid_vec;
    logic [qsz-1:0]             squash;
    logic [qsz-1:0]             eligible;
    logic [qsz-1:0]             alloc;
    logic [qsz-1:0][qsz-1:0]    alloc_row;
    logic [qsz-1:0]             picked;
    logic [iwd-1:0]             lane_acc;
    logic [iwd-1:0][qsz-1:0]    grant;
    logic [iwd-1:0][15:0]       sel_opid;
    logic [iwd-1:0][1:0][tgw-1:0] sel_prs;
    logic [iwd-1:0][pwd-1:0]    sel_payload;
    logic [cntw-1:0]            n_acc;
    logic [cntw-1:0]            n_iss;
    logic [cntw-1:0]            n_sq;
    logic                       redir_v;

    function automatic logic wake_hit(input logic [tgw-1:0] tag,
                                      input logic [wwd-1:0] v,
                                      input logic [wwd-1:0][tgw-1:0] t);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < wwd; k++) begin
            hit = hit | (v[k] && (t[k] == tag));
        end
        return hit;
    endfunction

    assign redir_v   = redir.opid[15];
    assign dis_ready = (count <= dis_lim);

    // Per-slot status: occupancy, flush victims, wakeup hits and select eligibility.
    always_comb begin
        for (int i = 0; i < qsz; i++) begin
            valid_vec[i] = entries[i].valid;
            squash[i]    = redir_v & entries[i].valid & precedes(entries[i].opid, redir);
            eligible[i]  = alu_ready & entries[i].valid & (&entries[i].rdy) & ~squash[i];
            for (int s = 0; s < 2; s++) begin
                wake_res[i][s] = wake_hit(entries[i].prs[s], wk_valid, wk_tag);
            end
        end
    end

    // Accepted lanes take the lowest free slots in lane order; each row marks residents and lower lanes older.
    always_comb begin
        logic [qsz-1:0] taken;
        logic [qsz-1:0] lower;
        logic           found;
        taken     = valid_vec;
        lower     = '0;
        alloc     = '0;
        alloc_row = '0;
        lane_acc  = '0;
        for (int i = 0; i < qsz; i++) begin
            alloc_lane[i] = '0;
        end
        for (int l = 0; l < iwd; l++) begin
            lane_new[l].valid   = 1'b1;
            lane_new[l].opid    = dis_opid[l];
            lane_new[l].prs     = dis_prs[l];
            lane_new[l].payload = dis_payload[l];
            for (int s = 0; s < 2; s++) begin
                lane_new[l].rdy[s] = dis_rdy[l][s] | (dis_prs[l][s] == '0) |
                                     wake_hit(dis_prs[l][s], wk_valid, wk_tag);
            end
            lane_acc[l] = dis_ready & dis_valid[l] & dis_opid[l][15] & ~redir_v;
            found = 1'b0;
            if (lane_acc[l]) begin
                for (int i = 0; i < qsz; i++) begin
                    if (!found && !taken[i]) begin
                        found         = 1'b1;
                        taken[i]      = 1'b1;
                        alloc[i]      = 1'b1;
                        alloc_lane[i] = lnw'(l);
                        alloc_row[i]  = valid_vec | lower;
                    end
                end
                lower = lower | (taken & ~valid_vec);
            end
        end
    end

    alu_sched_age_select u_age_select (
        .clk       (clk),
        .rst       (rst),
        .alloc     (alloc),
        .alloc_row (alloc_row),
        .eligible  (eligible),
        .grant     (grant)
    );

    // Gather the granted entries into issue lanes; grants are one-hot so a plain select suffices.
    always_comb begin
        picked      = '0;
        sel_opid    = '0;
        sel_prs     = '0;
        sel_payload = '0;
        for (int r = 0; r < iwd; r++) begin
            for (int i = 0; i < qsz; i++) begin
                if (grant[r][i]) begin
                    sel_opid[r]    = entries[i].opid;
                    sel_prs[r]     = entries[i].prs;
                    sel_payload[r] = entries[i].payload;
                end
            end
            picked = picked | grant[r];
        end
        n_acc = cntw'($countones(lane_acc));
        n_iss = cntw'($countones(picked));
        n_sq  = cntw'($countones(squash));
    end

    // Entry state: flush and issue free slots, dispatch fills free slots, wakeups set ready bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < qsz; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < qsz; i++) begin
                if (squash[i] || picked[i]) begin
                    entries[i].valid <= 1'b0;
                end else if (alloc[i]) begin
                    entries[i] <= lane_new[alloc_lane[i]];
                end else if (entries[i].valid) begin
                    entries[i].rdy <= entries[i].rdy | wake_res[i];
                end
            end
        end
    end

    // Issue bundle reloads every cycle, so lanes holding flushed ops drop out automatically.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid   <= '0;
            iss_opid    <= '0;
            iss_prs     <= '0;
            iss_payload <= '0;
        end else begin
            for (int r = 0; r < iwd; r++) begin
                iss_valid[r] <= |grant[r];
            end
            iss_opid    <= sel_opid;
            iss_prs     <= sel_prs;
            iss_payload <= sel_payload;
        end
    end

    // Occupancy tracks dispatch in, issue out and flush out in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count + n_acc - n_iss - n_sq;
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: reset, issue, wakeup, full queue, flush and opid wrap.
module tb_alu_sched;
    import alu_sched_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst;
    red_bundle_t                   redir;
    logic                          dis_ready;
    logic [iwd-1:0]                dis_valid;
    logic [iwd-1:0][15:0]          dis_opid;
    logic [iwd-1:0][1:0][tgw-1:0]  dis_prs;
    logic [iwd-1:0][1:0]           dis_rdy;
    logic [iwd-1:0][pwd-1:0]       dis_payload;
    logic [wwd-1:0]                wk_valid;
    logic [wwd-1:0][tgw-1:0]       wk_tag;
    logic                          alu_ready;
    logic [iwd-1:0]                iss_valid;
    logic [iwd-1:0][15:0]          iss_opid;
    logic [iwd-1:0][1:0][tgw-1:0]  iss_prs;
    logic [iwd-1:0][pwd-1:0]       iss_payload;
    logic [cntw-1:0]               count;

    int assert_count = 0;
    int fail_count   = 0;

    always #5 clk = ~clk;

    alu_sched dut (
        .clk         (clk),
        .rst         (rst),
        .redir       (redir),
        .dis_ready   (dis_ready),
        .dis_valid   (dis_valid),
        .dis_opid    (dis_opid),
        .dis_prs     (dis_prs),
        .dis_rdy     (dis_rdy),
        .dis_payload (dis_payload),
        .wk_valid    (wk_valid),
        .wk_tag      (wk_tag),
        .alu_ready   (alu_ready),
        .iss_valid   (iss_valid),
        .iss_opid    (iss_opid),
        .iss_prs     (iss_prs),
        .iss_payload (iss_payload),
        .count       (count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic clearInputs();
        redir       = '0;
        dis_valid   = '0;
        dis_opid    = '0;
        dis_prs     = '0;
        dis_rdy     = '0;
        dis_payload = '0;
        wk_valid    = '0;
        wk_tag      = '0;
    endtask

    task automatic applyStimulus(input int lane, input logic [15:0] opid,
                                 input logic [tgw-1:0] p0, input logic [tgw-1:0] p1,
                                 input logic [1:0] rdy);
        dis_valid[lane]   = 1'b1;
        dis_opid[lane]    = opid;
        dis_prs[lane][0]  = p0;
        dis_prs[lane][1]  = p1;
        dis_rdy[lane]     = rdy;
        dis_payload[lane] = {(pwd/16){opid}};
    endtask

    task automatic wake2(input logic [tgw-1:0] a, input logic [tgw-1:0] b);
        wk_valid  = 4'b0011;
        wk_tag[0] = a;
        wk_tag[1] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        alu_ready = 1'b1;
        clearInputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state held for three idle cycles
        for (int c = 0; c < 3; c++) begin
            checkOutput("reset_count", 32'(count), 32'd0);
            checkOutput("reset_dis_ready", 32'(dis_ready), 32'd1);
            checkOutput("reset_iss_valid", 32'(iss_valid), 32'd0);
            tick();
        end
        checkOutput("reset_iss_opid0", 32'(iss_opid[0]), 32'd0);

        // Four ready ops issue together the cycle after dispatch
        for (int l = 0; l < 4; l++) applyStimulus(l, 16'h8001 + 16'(l), 7'd5, 7'd6, 2'b11);
        tick();
        clearInputs();
        checkOutput("burst_count_after_dispatch", 32'(count), 32'd4);
        checkOutput("burst_iss_valid_early", 32'(iss_valid), 32'd0);
        tick();
        checkOutput("burst_iss_valid", 32'(iss_valid), 32'hF);
        for (int l = 0; l < 4; l++) checkOutput("burst_iss_opid", 32'(iss_opid[l]), 32'h8001 + 32'(l));
        checkOutput("burst_payload", iss_payload[2][31:0], 32'h80038003);
        checkOutput("burst_count_drained", 32'(count), 32'd0);
        tick();
        checkOutput("burst_idle", 32'(iss_valid), 32'd0);

        // ALU back-pressure holds a ready op until alu_ready returns
        alu_ready = 1'b0;
        applyStimulus(0, 16'h8005, 7'd5, 7'd6, 2'b11);
        tick();
        clearInputs();
        tick();
        checkOutput("stall_iss_valid", 32'(iss_valid), 32'd0);
        checkOutput("stall_count", 32'(count), 32'd1);
        alu_ready = 1'b1;
        tick();
        checkOutput("stall_release_valid", 32'(iss_valid), 32'd1);
        checkOutput("stall_release_opid", 32'(iss_opid[0]), 32'h8005);

        // Wakeup on tag 9 two cycles after dispatch; selectable the cycle after the wakeup edge
        applyStimulus(0, 16'h8010, 7'd7, 7'd9, 2'b01);
        tick();
        clearInputs();
        checkOutput("wake_count", 32'(count), 32'd1);
        tick();
        checkOutput("wake_wait_valid", 32'(iss_valid), 32'd0);
        wk_valid  = 4'b0100;
        wk_tag[2] = 7'd9;
        tick();
        clearInputs();
        checkOutput("wake_edge_valid", 32'(iss_valid), 32'd0);
        tick();
        checkOutput("wake_issue_valid", 32'(iss_valid), 32'd1);
        checkOutput("wake_issue_opid", 32'(iss_opid[0]), 32'h8010);
        checkOutput("wake_issue_prs", 32'(iss_prs[0]), (32'd9 << 7) | 32'd7);
        checkOutput("wake_count_zero", 32'(count), 32'd0);

        // Same-cycle wakeup bypass plus x0 source
        applyStimulus(0, 16'h8011, 7'd9, 7'd0, 2'b00);
        wk_valid  = 4'b0001;
        wk_tag[0] = 7'd9;
        tick();
        clearInputs();
        checkOutput("bypass_early_valid", 32'(iss_valid), 32'd0);
        tick();
        checkOutput("bypass_valid", 32'(iss_valid), 32'd1);
        checkOutput("bypass_opid", 32'(iss_opid[0]), 32'h8011);

        // Fill the queue with blocked ops; dis_ready drops once fewer than four slots remain
        for (int g = 0; g < 4; g++) begin
            for (int l = 0; l < 4; l++) applyStimulus(l, 16'h8020 + 16'(4*g + l), 7'd11, 7'd12, 2'b00);
            tick();
            clearInputs();
            checkOutput("fill_count", 32'(count), 32'(4*(g+1)));
            checkOutput("fill_dis_ready", 32'(dis_ready), (g < 3) ? 32'd1 : 32'd0);
        end
        applyStimulus(0, 16'h8030, 7'd5, 7'd6, 2'b11);
        tick();
        clearInputs();
        checkOutput("full_count_held", 32'(count), 32'd16);
        checkOutput("full_dis_ready", 32'(dis_ready), 32'd0);
        checkOutput("full_no_issue", 32'(iss_valid), 32'd0);
        wake2(7'd11, 7'd12);
        tick();
        clearInputs();
        checkOutput("drain_wake_edge", 32'(iss_valid), 32'd0);
        for (int b = 0; b < 4; b++) begin
            tick();
            checkOutput("drain_valid", 32'(iss_valid), 32'hF);
            for (int l = 0; l < 4; l++) checkOutput("drain_opid", 32'(iss_opid[l]), 32'h8020 + 32'(4*b + l));
            checkOutput("drain_count", 32'(count), 32'(16 - 4*(b+1)));
        end
        tick();
        checkOutput("drain_idle", 32'(iss_valid), 32'd0);

        // Flush younger than 0x8007 with topid 0x8003; same-cycle dispatch is dropped
        for (int l = 0; l < 4; l++) applyStimulus(l, 16'h8005 + 16'(l), 7'd13, 7'd14, 2'b00);
        tick();
        clearInputs();
        applyStimulus(0, 16'h8009, 7'd13, 7'd14, 2'b00);
        applyStimulus(1, 16'h800A, 7'd13, 7'd14, 2'b00);
        tick();
        clearInputs();
        checkOutput("flush_pre_count", 32'(count), 32'd6);
        redir.opid  = 16'h8007;
        redir.topid = 16'h8003;
        applyStimulus(0, 16'h800B, 7'd5, 7'd6, 2'b11);
        tick();
        clearInputs();
        checkOutput("flush_count", 32'(count), 32'd3);
        checkOutput("flush_no_issue", 32'(iss_valid), 32'd0);
        wake2(7'd13, 7'd14);
        tick();
        clearInputs();
        tick();
        checkOutput("flush_survivors_valid", 32'(iss_valid), 32'b0111);
        for (int l = 0; l < 3; l++) checkOutput("flush_survivor_opid", 32'(iss_opid[l]), 32'h8005 + 32'(l));
        checkOutput("flush_drained", 32'(count), 32'd0);

        // Flush across the opid wrap: topid 0x803E, redirect 0x803F
        applyStimulus(0, 16'h803F, 7'd15, 7'd16, 2'b00);
        applyStimulus(1, 16'h8000, 7'd15, 7'd16, 2'b00);
        applyStimulus(2, 16'h8001, 7'd15, 7'd16, 2'b00);
        tick();
        clearInputs();
        checkOutput("wrap_pre_count", 32'(count), 32'd3);
        redir.opid  = 16'h803F;
        redir.topid = 16'h803E;
        tick();
        clearInputs();
        checkOutput("wrap_flush_count", 32'(count), 32'd1);
        wake2(7'd15, 7'd16);
        tick();
        clearInputs();
        tick();
        checkOutput("wrap_survivor_valid", 32'(iss_valid), 32'b0001);
        checkOutput("wrap_survivor_opid", 32'(iss_opid[0]), 32'h803F);
        checkOutput("wrap_drained", 32'(count), 32'd0);

        // Age order across wrap and reused slots: slot order differs from age order
        applyStimulus(0, 16'h803C, 7'd5, 7'd6, 2'b11);
        applyStimulus(1, 16'h803F, 7'd17, 7'd18, 2'b00);
        tick();
        clearInputs();
        applyStimulus(0, 16'h8000, 7'd17, 7'd18, 2'b00);
        applyStimulus(1, 16'h8001, 7'd17, 7'd18, 2'b00);
        tick();
        clearInputs();
        checkOutput("age_filler_valid", 32'(iss_valid), 32'b0001);
        checkOutput("age_filler_opid", 32'(iss_opid[0]), 32'h803C);
        checkOutput("age_mid_count", 32'(count), 32'd3);
        applyStimulus(0, 16'h8002, 7'd17, 7'd18, 2'b00);
        tick();
        clearInputs();
        checkOutput("age_full_count", 32'(count), 32'd4);
        wake2(7'd17, 7'd18);
        tick();
        clearInputs();
        tick();
        checkOutput("age_issue_valid", 32'(iss_valid), 32'hF);
        checkOutput("age_lane0", 32'(iss_opid[0]), 32'h803F);
        checkOutput("age_lane1", 32'(iss_opid[1]), 32'h8000);
        checkOutput("age_lane2", 32'(iss_opid[2]), 32'h8001);
        checkOutput("age_lane3", 32'(iss_opid[3]), 32'h8002);
        checkOutput("age_drained", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Out-of-order issue queue and scheduler feeding the integer ALU cluster.
- Holds renamed ALU ops after dispatch and tracks source-operand readiness via physical-tag wakeup broadcasts.
- Each cycle, selects up to iwd ready ops oldest-first and presents them in a registered issue bundle ahead of register read, gated by the ALU's ready signal.
- Squashes younger-than-redirect entries on a branch redirect.

Parameters:
- iwd, 4, dispatch and issue width (equals the ALU's request width)
- qsz, 16, queue entries; must be >= iwd
- opsz, 64, operation-ID ring size (used for flush ordering)
- prn, 128, physical registers; tgw = $clog2(prn)
- wwd, 4, wakeup broadcast ports
- pwd, 256, opaque payload width (funct, immediates, pc, ...)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redir  in  red_bundle_t  redirect; valid = redir.opid[15]; fields used: opid, topid
- dis_ready  out  1  queue can accept iwd ops this cycle
- dis_valid  in  iwd  dispatch lane valid
- dis_opid  in  iwd x 16  operation ID; bit 15 = valid
- dis_prs  in  iwd x 2 x tgw  source physical tags
- dis_rdy  in  iwd x 2  source already available at dispatch
- dis_payload  in  iwd x pwd  opaque payload
- wk_valid  in  wwd  wakeup valid
- wk_tag  in  wwd x tgw  tag becoming available
- alu_ready  in  1  ALU can take iwd requests
- iss_valid  out  iwd  issue lane valid (lanes packed from lane 0)
- iss_opid  out  iwd x 16  issued op ID
- iss_prs  out  iwd x 2 x tgw  tags for register read
- iss_payload  out  iwd x pwd  payload
- count  out  $clog2(qsz)+1  occupied entries

Behaviour:
- Reset (async): all entries invalid; age matrix cleared; iss_valid = 0; iss_opid = 0; count = 0; dis_ready = 1.
- dis_ready = (qsz - count >= iwd), combinational from registered count. Slots freed by issue in the same cycle are not credited.
- Dispatch:
  - Lane i is accepted when dis_ready & dis_valid[i] & dis_opid[i][15].
  - Accepted lanes fill the lowest-index free slots in lane order.
  - A dispatched lane's age-matrix row marks all currently valid entries and all lower accepted lanes as older.
- Readiness:
  - Per-source ready bit = dis_rdy, OR tag == 0 (x0), OR a same-cycle wk_valid/wk_tag match (bypass).
  - For resident entries, a wakeup at edge t sets the bit; the entry is selectable from cycle t+1.
- Selection:
  - Combinational in cycle t, performed only when alu_ready = 1.
  - Eligible = valid & both ready & not squashed this cycle.
  - Pick up to iwd eligible entries in strict age order: the entry with no older eligible unpicked entry goes first.
  - Picked entries are freed at edge t.
- Issue register:
  - At edge t, the picked ops load into iss_* lanes 0..k-1; other lanes get iss_valid = 0.
  - One-cycle latency from eligibility to iss_valid.
  - If alu_ready = 0, all iss_valid = 0 the next cycle.
- Flush:
  - Let w = $clog2(opsz), with w-bit wrapped subtraction.
  - While redir valid, entry X is squashed iff (X.opid - topid) >= (redir.opid - topid) + 1.
  - Squashed entries are invalidated at the edge.
  - All dispatch in a redirect cycle is dropped.
  - Issue-register lanes holding squashed IDs have iss_valid cleared at the edge.
  - Squashed entries are never selected.
  - The redirecting op itself survives.
- Simultaneous events:
  - Flush beats wakeup and select.
  - Issue and dispatch in the same cycle are both honoured.
  - count_next = count + accepted - issued - squashed.
- Full: with count > qsz - iwd, dis_ready = 0 and dispatch is ignored even if dis_valid is high.
- Wrap-around: opid ordering relies only on the wrapped difference; the age matrix is independent of opid wrap.

Decomposition:
- Shared types package gains:
  - sched_entry_t: valid, opid, prs[2], rdy[2], payload.
  - A function precedes(opid, redir) that implements the flush ordering; the ALU and other queues reuse it.
- One natural sub-module, age_select: qsz-entry age matrix plus oldest-first iwd-pick network, with an eligible-vector input and iwd one-hot grant outputs.

Test Plan:
- Reset held, then released → count = 0, dis_ready = 1, iss_valid = 0 for 3 cycles.
- Dispatch 4 ops (opid 0x8001–0x8004), all dis_rdy = 1, alu_ready = 1 → next cycle iss_valid = 4'b1111, iss_opid in dispatch order; count returns to 0.
- Dispatch op A with prs = {7, 9}, rdy = {1, 0}; wk_tag = 9 two cycles later → A issues exactly one cycle after the wakeup edge. A second dispatch with wk_tag = 9 in the same cycle issues the following cycle.
- Fill 16 entries with non-ready sources → after 3 dispatch groups dis_ready = 1, after 4 dis_ready = 0; a further dis_valid is ignored, count stays 16.
- Queue holds opids 0x8005–0x800A, redir.opid = 0x8007, topid = 0x8003 → 0x8008–0x800A removed; count = 3; same-cycle dispatch dropped.
- opid wrap: topid = 0x803E, entries 0x803F, 0x8000, 0x8001, redir.opid = 0x803F → 0x8000 and 0x8001 squashed; oldest-first issue order 0x803F first when all are ready.
